spw_babasu_pll_supervisor: RTL and testbench

SPW_BABASU_PLL_SUPERVISOR -- requirements
Module: spw_babasu_pll_supervisor

---
 rtl/spw_babasu_pll_supervisor.sv | 110 +++++++++++
 tb/tb_spw_babasu_pll_supervisor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spw_babasu_pll_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, qualifies lock for a stable
// window, then releases downstream SpaceWire reset; tracks lock losses/timeouts.
module spw_babasu_pll_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] retry_cnt,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_PLL_RST   = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_STABLE    = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  localparam logic [CNT_W-1:0] PRST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             r_sync1;
  logic             r_locked_s;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic             r_ready;
  logic [7:0]       r_loss_cnt;
  logic [7:0]       r_retry_cnt;

  logic [1:0]       w_next;
  logic             w_loss_inc;
  logic             w_retry_inc;

  // Lock loss takes priority over relock_req so a simultaneous event is counted.
  always_comb begin
    w_next      = r_state;
    w_loss_inc  = 1'b0;
    w_retry_inc = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == PRST_LAST) w_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (r_locked_s) begin
          w_next = S_STABLE;
        end else if (r_cnt == TMO_LAST) begin
          w_next      = S_PLL_RST;
          w_retry_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (!r_locked_s)            w_next = S_WAIT_LOCK;
        else if (r_cnt == STB_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        if (!r_locked_s) begin
          w_next     = S_PLL_RST;
          w_loss_inc = 1'b1;
        end else if (relock_req) begin
          w_next = S_PLL_RST;
        end
      end
      default: w_next = S_PLL_RST;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b0;
      r_locked_s  <= 1'b0;
      r_state     <= S_PLL_RST;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_loss_cnt  <= 8'd0;
      r_retry_cnt <= 8'd0;
    end else begin
      r_sync1    <= pll_locked;
      r_locked_s <= r_sync1;
      r_state    <= w_next;
      r_cnt      <= (w_next != r_state) ? '0 : r_cnt + CNT_ONE;
      // Outputs decode the next state so they flip on the same edge as the state.
      r_pll_rst   <= (w_next == S_PLL_RST);
      r_sys_rst_n <= (w_next == S_RUN);
      r_ready     <= (w_next == S_RUN);
      if (w_loss_inc && (r_loss_cnt != 8'hFF))   r_loss_cnt  <= r_loss_cnt + 8'd1;
      if (w_retry_inc && (r_retry_cnt != 8'hFF)) r_retry_cnt <= r_retry_cnt + 8'd1;
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_rst_n     = r_sys_rst_n;
  assign ready         = r_ready;
  assign lock_loss_cnt = r_loss_cnt;
  assign retry_cnt     = r_retry_cnt;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_spw_babasu_pll_supervisor.sv
// Bench for spw_babasu_pll_supervisor: a default-parameter instance for the
// long timing windows and a short-parameter instance for the state-walk table.
module tb_spw_babasu_pll_supervisor;

  localparam logic [1:0] ST_PRST   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STABLE = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Short-parameter instance: 16 reset, 8 stable, 20 timeout
  logic       f_rst_n = 1'b0, f_locked = 1'b0, f_relock = 1'b0;
  logic       f_pll_rst, f_sys_rst_n, f_ready;
  logic [7:0] f_loss, f_retry;
  logic [1:0] f_state;

  // Default-parameter instance
  logic       d_rst_n = 1'b0, d_locked = 1'b0, d_relock = 1'b0;
  logic       d_pll_rst, d_sys_rst_n, d_ready;
  logic [7:0] d_loss, d_retry;
  logic [1:0] d_state;

  spw_babasu_pll_supervisor #(
    .PLL_RST_CYCLES(16), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(20), .CNT_W(16)
  ) u_dut (
    .refclk(clk), .rst_n(f_rst_n), .pll_locked(f_locked), .relock_req(f_relock),
    .pll_rst(f_pll_rst), .sys_rst_n(f_sys_rst_n), .ready(f_ready),
    .lock_loss_cnt(f_loss), .retry_cnt(f_retry), .dbg_state(f_state)
  );

  spw_babasu_pll_supervisor u_def (
    .refclk(clk), .rst_n(d_rst_n), .pll_locked(d_locked), .relock_req(d_relock),
    .pll_rst(d_pll_rst), .sys_rst_n(d_sys_rst_n), .ready(d_ready),
    .lock_loss_cnt(d_loss), .retry_cnt(d_retry), .dbg_state(d_state)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string name, input logic [1:0] target, input int budget);
    int n;
    n = 0;
    while (f_state !== target && n < budget) begin
      step(1);
      n++;
    end
    chk({name, "_reached"}, {30'd0, f_state}, {30'd0, target});
  endtask

  typedef struct {
    logic       rst_n;
    logic       locked;
    logic       relock;
    int         ncyc;
    logic [1:0] st;
    logic       prst;
    logic       srn;
    logic       rdy;
    logic [7:0] loss;
    logic [7:0] retry;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic l, input logic q, input int n,
                              input logic [1:0] s, input logic p, input logic sr,
                              input logic rd, input logic [7:0] lc, input logic [7:0] rc);
    vec_t v;
    v.rst_n = r; v.locked = l; v.relock = q; v.ncyc = n;
    v.st = s; v.prst = p; v.srn = sr; v.rdy = rd; v.loss = lc; v.retry = rc;
    return v;
  endfunction

  initial begin
    // Table: inputs held for ncyc edges, then outputs compared.
    vt.push_back(mk(0, 0, 0,  2, ST_PRST,   1, 0, 0, 0, 0)); // in reset
    vt.push_back(mk(1, 0, 0, 15, ST_PRST,   1, 0, 0, 0, 0)); // edge 15
    vt.push_back(mk(1, 0, 0,  1, ST_WAIT,   0, 0, 0, 0, 0)); // edge 16
    vt.push_back(mk(1, 1, 0,  2, ST_WAIT,   0, 0, 0, 0, 0)); // sync latency
    vt.push_back(mk(1, 1, 0,  1, ST_STABLE, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0,  7, ST_STABLE, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0,  1, ST_RUN,    0, 1, 1, 0, 0));
    vt.push_back(mk(1, 0, 0,  2, ST_RUN,    0, 1, 1, 0, 0)); // loss in sync
    vt.push_back(mk(1, 0, 0,  1, ST_PRST,   1, 0, 0, 1, 0)); // lock loss
    vt.push_back(mk(1, 1, 0, 15, ST_PRST,   1, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 0,  1, ST_WAIT,   0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 0,  1, ST_STABLE, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 0,  3, ST_STABLE, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 0, 0,  3, ST_WAIT,   0, 0, 0, 1, 0)); // glitch
    vt.push_back(mk(1, 1, 0,  2, ST_WAIT,   0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 0,  1, ST_STABLE, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 0,  7, ST_STABLE, 0, 0, 0, 1, 0)); // full requal
    vt.push_back(mk(1, 1, 0,  1, ST_RUN,    0, 1, 1, 1, 0));
    vt.push_back(mk(1, 1, 1,  1, ST_PRST,   1, 0, 0, 1, 0)); // relock, uncounted
    vt.push_back(mk(1, 1, 1, 15, ST_PRST,   1, 0, 0, 1, 0)); // relock ignored
    vt.push_back(mk(1, 1, 1,  1, ST_WAIT,   0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 1,  1, ST_STABLE, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 1,  7, ST_STABLE, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 0,  1, ST_RUN,    0, 1, 1, 1, 0));
    vt.push_back(mk(1, 0, 0,  2, ST_RUN,    0, 1, 1, 1, 0));
    vt.push_back(mk(1, 0, 1,  1, ST_PRST,   1, 0, 0, 2, 0)); // loss + relock
    vt.push_back(mk(1, 0, 0, 16, ST_WAIT,   0, 0, 0, 2, 0));
    vt.push_back(mk(1, 0, 0, 19, ST_WAIT,   0, 0, 0, 2, 0));
    vt.push_back(mk(1, 0, 0,  1, ST_PRST,   1, 0, 0, 2, 1)); // timeout
    vt.push_back(mk(1, 0, 0, 15, ST_PRST,   1, 0, 0, 2, 1));
    vt.push_back(mk(1, 0, 0,  1, ST_WAIT,   0, 0, 0, 2, 1));
    vt.push_back(mk(1, 0, 0, 19, ST_WAIT,   0, 0, 0, 2, 1));
    vt.push_back(mk(1, 0, 0,  1, ST_PRST,   1, 0, 0, 2, 2));

    // Default instance: reset values, reset-pulse width, lock qualification window
    step(2);
    chk("def_rst_pll_rst", {31'd0, d_pll_rst}, 32'd1);
    chk("def_rst_srn", {31'd0, d_sys_rst_n}, 32'd0);
    chk("def_rst_ready", {31'd0, d_ready}, 32'd0);
    chk("def_rst_cnts", {16'd0, d_loss, d_retry}, 32'd0);
    d_rst_n = 1'b1;
    step(15);
    chk("def_e15_pll_rst", {31'd0, d_pll_rst}, 32'd1);
    step(1);
    chk("def_e16_pll_rst", {31'd0, d_pll_rst}, 32'd0);
    chk("def_e16_state", {30'd0, d_state}, {30'd0, ST_WAIT});
    d_locked = 1'b1;
    step(2);
    chk("def_e18_state", {30'd0, d_state}, {30'd0, ST_WAIT});
    step(1);
    chk("def_e19_state", {30'd0, d_state}, {30'd0, ST_STABLE});
    step(1023);
    chk("def_e1042_ready", {31'd0, d_ready}, 32'd0);
    chk("def_e1042_srn", {31'd0, d_sys_rst_n}, 32'd0);
    step(1);
    chk("def_e1043_ready", {31'd0, d_ready}, 32'd1);
    chk("def_e1043_srn", {31'd0, d_sys_rst_n}, 32'd1);
    chk("def_e1043_state", {30'd0, d_state}, {30'd0, ST_RUN});
    d_rst_n = 1'b0;

    // Table-driven walk of the short instance
    for (int i = 0; i < vt.size(); i++) begin
      f_rst_n  = vt[i].rst_n;
      f_locked = vt[i].locked;
      f_relock = vt[i].relock;
      step(vt[i].ncyc);
      chk($sformatf("v%0d_state", i), {30'd0, f_state}, {30'd0, vt[i].st});
      chk($sformatf("v%0d_pll_rst", i), {31'd0, f_pll_rst}, {31'd0, vt[i].prst});
      chk($sformatf("v%0d_srn", i), {31'd0, f_sys_rst_n}, {31'd0, vt[i].srn});
      chk($sformatf("v%0d_ready", i), {31'd0, f_ready}, {31'd0, vt[i].rdy});
      chk($sformatf("v%0d_loss", i), {24'd0, f_loss}, {24'd0, vt[i].loss});
      chk($sformatf("v%0d_retry", i), {24'd0, f_retry}, {24'd0, vt[i].retry});
    end
    f_relock = 1'b0;

    // Asynchronous reset while in RUN with nonzero counters
    f_locked = 1'b1;
    wait_state("run_before_arst", ST_RUN, 200);
    #2;
    f_rst_n = 1'b0;
    #1;
    chk("arst_state", {30'd0, f_state}, {30'd0, ST_PRST});
    chk("arst_pll_rst", {31'd0, f_pll_rst}, 32'd1);
    chk("arst_srn", {31'd0, f_sys_rst_n}, 32'd0);
    chk("arst_ready", {31'd0, f_ready}, 32'd0);
    chk("arst_loss", {24'd0, f_loss}, 32'd0);
    chk("arst_retry", {24'd0, f_retry}, 32'd0);
    f_rst_n = 1'b1;
    step(15);
    chk("arst_e15_pll_rst", {31'd0, f_pll_rst}, 32'd1);
    step(1);
    chk("arst_e16_pll_rst", {31'd0, f_pll_rst}, 32'd0);

    // Lock-loss counter saturation
    for (int i = 0; i < 300; i++) begin
      f_locked = 1'b1;
      wait_state("loss_run", ST_RUN, 100);
      f_locked = 1'b0;
      wait_state("loss_prst", ST_PRST, 10);
      if (i == 9) chk("loss_after_10", {24'd0, f_loss}, 32'd10);
    end
    chk("loss_saturated", {24'd0, f_loss}, 32'd255);

    // Retry counter cadence and saturation
    step(1);
    f_rst_n = 1'b0;
    step(1);
    f_rst_n = 1'b1;
    f_locked = 1'b0;
    step(35);
    chk("retry_e35_cnt", {24'd0, f_retry}, 32'd0);
    chk("retry_e35_state", {30'd0, f_state}, {30'd0, ST_WAIT});
    step(1);
    chk("retry_e36_cnt", {24'd0, f_retry}, 32'd1);
    chk("retry_e36_pll_rst", {31'd0, f_pll_rst}, 32'd1);
    step(36);
    chk("retry_e72_cnt", {24'd0, f_retry}, 32'd2);
    step(300 * 36);
    chk("retry_saturated", {24'd0, f_retry}, 32'd255);
    chk("retry_loss_clear", {24'd0, f_loss}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
